cache_req_arbiter: RTL
======================

Name: cache_req_arbiter

Overview:
- Shares the single-port cache controller among N_REQ requesters using round-robin arbitration.
- Latches the winner's address and read/write flag, then issues a one-cycle start to the controller.
- Waits for the controller's done, with a timeout, and returns the data word to the winner with a valid pulse.
- Sits between the requester ports (CPU fetch, CPU data, DMA, debug) and the cache controller.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 5, address width presented to the cache controller
DATA_W, 32, data word width
TIMEOUT, 15, max WAIT cycles before aborting with error (1..255)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; one clock; reset is asynchronous and active-high
i_req  in  N_REQ  per-requester request level
i_addr  in  N_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
i_wr  in  N_REQ  per-requester write flag
o_gnt  out  N_REQ  one-hot grant, held ISSUE..RESP
o_rsp_valid  out  N_REQ  one-cycle response strobe to granted requester
o_rsp_err  out  1  qualifies o_rsp_valid: 1 = timeout abort
o_rsp_data  out  DATA_W  response data, valid with o_rsp_valid
o_cc_en  out  1  controller enable, high in ISSUE and WAIT
o_cc_start  out  1  one-cycle start pulse to controller
o_cc_addr  out  ADDR_W  latched address of current transaction
o_cc_wr  out  1  latched write flag
i_cc_done  in  1  controller completion
i_cc_data  in  DATA_W  controller read data, valid with i_cc_done

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; RR pointer 0; timeout counter 0; bubble flag 0. Applies mid-transaction; the in-flight transaction is dropped with no response.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If bubble flag is clear and any i_req is set, select the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Next edge: o_gnt one-hot; latch o_cc_addr/o_cc_wr from that requester; o_cc_start=1, o_cc_en=1; go to ISSUE.
  - Bubble flag clears in IDLE.
- ISSUE (1 cycle): next edge o_cc_start=0; timeout counter=0; go to WAIT. i_cc_done is ignored in ISSUE.
- WAIT:
  - On i_cc_done=1: capture i_cc_data into o_rsp_data; o_rsp_err=0; go to RESP.
  - Else if counter==TIMEOUT-1: o_rsp_data=0; o_rsp_err=1; go to RESP.
  - Else counter++.
  - Done on the final timeout cycle wins (no error).
  - Leaving WAIT: o_cc_en=0.
- RESP (1 cycle):
  - o_rsp_valid bit of the granted requester =1.
  - Next edge: o_gnt=0, o_rsp_valid=0, o_rsp_err=0; pointer = granted index + 1 (wraps N_REQ-1 -> 0); bubble flag=1; go to IDLE.
- Latency:
  - Request sampled in IDLE at edge 0: ISSUE from edge 1. With done in the first WAIT cycle, WAIT at edge 2 and RESP at edge 3.
  - Minimum request-to-rsp_valid is 3 cycles; back-to-back transactions every 5 cycles minimum (includes the 1-cycle bubble).
- Requester rules:
  - Hold i_req, i_addr and i_wr until the rsp_valid cycle; drop or re-request afterwards.
  - Address/wr changes after grant are ignored (already latched).
  - Dropping i_req mid-transaction does not abort; the response is still issued.
- The bubble cycle guarantees a requester that sees rsp_valid is not regranted from a stale i_req level.
- With no i_req set, stay in IDLE with o_cc_en=0.
- Out-of-range and zero-width cases are not supported; parameters are restricted to the ranges stated above.

Test Plan:
- Single request: i_req=0001, i_addr[0]=5'h0A, i_wr=0; i_cc_done=1 with i_cc_data=32'hDEADBEEF on first WAIT cycle -> o_cc_start one pulse with o_cc_addr=0x0A; o_rsp_valid=0001 at edge 3; o_rsp_data=DEADBEEF; o_rsp_err=0.
- Fairness: i_req=1111 held continuously, controller done every first WAIT cycle -> grant order 0,1,2,3,0, one grant per 5 cycles; never two grants without a rotation.
- Timeout: i_req=0100, i_cc_done held 0 -> rsp_valid=0100 after exactly TIMEOUT WAIT cycles (15); o_rsp_err=1, o_rsp_data=0; next grant goes to requester 3 if pending.
- Done ignored in ISSUE: i_cc_done=1 only in the ISSUE cycle -> stays in WAIT; no response until a later done or timeout.
- Reset mid-WAIT: assert i_rst asynchronously between edges in WAIT -> all outputs 0 immediately; no rsp_valid after release; the first grant after release goes to requester 0 (pointer reset).
- Request withdrawn: requester 1 granted, i_req[1] dropped and i_addr[1] changed in WAIT -> o_cc_addr unchanged; rsp_valid=0010 still issued.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one single-port cache controller among
// N_REQ requesters. It latches the winner's address and write flag, sends the
// controller a one-cycle start and waits for done, with a timeout. The data
// word then returns to the winner with a one-cycle valid strobe. After each
// response it spends one bubble cycle, so a requester's stale request level
// cannot win the arbitration again straight away.
module cache_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    input  logic [N_REQ-1:0]        i_wr,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic                    o_rsp_err,
    output logic [DATA_W-1:0]       o_rsp_data,
    output logic                    o_cc_en,
    output logic                    o_cc_start,
    output logic [ADDR_W-1:0]       o_cc_addr,
    output logic                    o_cc_wr,
    input  logic                    i_cc_done,
    input  logic [DATA_W-1:0]       i_cc_data
);

    localparam int         PTR_W     = $clog2(N_REQ);
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;         // round-robin start position
    logic [PTR_W-1:0]  idx_q, idx_d;         // index of the granted requester
    logic [7:0]        cnt_q, cnt_d;         // WAIT cycles already spent
    logic              bubble_q, bubble_d;   // blocks arbitration for one IDLE cycle
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              cc_en_q, cc_en_d;
    logic              cc_start_q, cc_start_d;
    logic [ADDR_W-1:0] cc_addr_q, cc_addr_d;
    logic              cc_wr_q, cc_wr_d;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic              found;
    logic [PTR_W-1:0]  sel;

    // Split the packed address bus into one address per requester
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            addr_arr[k] = i_addr[k*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin pick: the first request at or after the pointer, wrapping at N_REQ
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        found    = 1'b0;
        sel      = ptr_q;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!found && i_req[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
    end

    // Next state and next register values for the arbitration FSM
    always_comb begin
        // NOTE: every value starts from its held copy, so a path that does not
        // assign it keeps its value. This stops the tool from inferring a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        bubble_d    = bubble_q;
        gnt_d       = gnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        cc_en_d     = cc_en_q;
        cc_start_d  = cc_start_q;
        cc_addr_d   = cc_addr_q;
        cc_wr_d     = cc_wr_q;

        unique case (state_q)
            IDLE: begin
                bubble_d = 1'b0;
                if (!bubble_q && found) begin
                    idx_d      = sel;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    cc_addr_d  = addr_arr[sel];
                    cc_wr_d    = i_wr[sel];
                    cc_start_d = 1'b1;
                    cc_en_d    = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Done is not accepted here; the controller has only just seen start.
                cc_start_d = 1'b0;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (i_cc_done) begin
                    rsp_data_d  = i_cc_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = gnt_q;
                    cc_en_d     = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == LAST_WAIT) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = gnt_q;
                    cc_en_d     = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                gnt_d       = '0;
                rsp_valid_d = '0;
                rsp_err_d   = 1'b0;
                ptr_d       = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                bubble_d    = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any transaction in flight without a response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            bubble_q    <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cc_en_q     <= 1'b0;
            cc_start_q  <= 1'b0;
            cc_addr_q   <= '0;
            cc_wr_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples values
            // from before the edge, no matter how the statements are ordered.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            bubble_q    <= bubble_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cc_en_q     <= cc_en_d;
            cc_start_q  <= cc_start_d;
            cc_addr_q   <= cc_addr_d;
            cc_wr_q     <= cc_wr_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_cc_en     = cc_en_q;
    assign o_cc_start  = cc_start_q;
    assign o_cc_addr   = cc_addr_q;
    assign o_cc_wr     = cc_wr_q;

endmodule
